// File: rtl/register_file_scoreboard_if.sv
// rtl/register_file_scoreboard_if.sv - read/claim/writeback bus of the register file scoreboard
//
// Purpose: groups the issue-side (read, claim) and writeback-side signals of
// register_file_scoreboard so they travel as one bundle.
// Signals:
//   read_enable, rs1, rs2        issue-stage read request
//   rs1_value, rs2_value         registered read data
//   rs1_busy, rs2_busy           pending-write flags for rs1/rs2
//   claim_enable, claim_rd       destination claim at issue
//   write_enable, rd, rd_value   writeback strobe, index, data
//   busy_count                   number of busy registers
// Modports: master drives requests (issue/writeback side), slave is the register file.

interface register_file_scoreboard_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              read_enable;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [XLEN-1:0]   rs1_value;
  logic [XLEN-1:0]   rs2_value;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              claim_enable;
  logic [ADDR_W-1:0] claim_rd;
  logic              write_enable;
  logic [ADDR_W-1:0] rd;
  logic [XLEN-1:0]   rd_value;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output read_enable, rs1, rs2, claim_enable, claim_rd, write_enable, rd, rd_value,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, busy_count
  );

  modport slave (
    input  read_enable, rs1, rs2, claim_enable, claim_rd, write_enable, rd, rd_value,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, busy_count
  );
endinterface

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - dual-read register file with registered reads and busy scoreboard
//
// Purpose: single-write, dual-read register file with 1-cycle registered reads,
// optional hard-wired zero register and a per-register busy scoreboard that
// lets issue detect RAW hazards against in-flight writes.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    register_file_scoreboard_if.slave (reads, claims, writeback, status)
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first: a read colliding with a write returns rd_value
//   undefined -> read-first: a read colliding with a write returns the old contents

module register_file_scoreboard #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  register_file_scoreboard_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [XLEN-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_count_q;
  logic [ADDR_W:0]   busy_count_d;
  logic [XLEN-1:0]   rs1_value_q;
  logic [XLEN-1:0]   rs1_value_d;
  logic [XLEN-1:0]   rs2_value_q;
  logic [XLEN-1:0]   rs2_value_d;

  logic              rs1_zero;
  logic              rs2_zero;
  logic              wr_ok;

  // Index 0 is the hard-wired zero register only when ZERO_REG is set.
  assign rs1_zero = (ZERO_REG != 0) && (bus.rs1 == '0);
  assign rs2_zero = (ZERO_REG != 0) && (bus.rs2 == '0);

  // A write that actually lands in storage.
  assign wr_ok = bus.write_enable && !((ZERO_REG != 0) && (bus.rd == '0));

  always_comb begin
    rs1_value_d = rs1_value_q;
    rs2_value_d = rs2_value_q;
    if (bus.read_enable) begin
      if (rs1_zero) begin
        rs1_value_d = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_ok && (bus.rd == bus.rs1)) begin
        rs1_value_d = bus.rd_value;
`endif
      end else begin
        rs1_value_d = regs_q[bus.rs1];
      end

      if (rs2_zero) begin
        rs2_value_d = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_ok && (bus.rd == bus.rs2)) begin
        rs2_value_d = bus.rd_value;
`endif
      end else begin
        rs2_value_d = regs_q[bus.rs2];
      end
    end
  end

  // Claim is applied after the write-clear so a same-edge claim (newer
  // producer) wins over the retiring write to the same register.
  always_comb begin
    busy_d = busy_q;
    if (bus.write_enable) begin
      busy_d[bus.rd] = 1'b0;
    end
    if (bus.claim_enable) begin
      busy_d[bus.claim_rd] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // Count is taken from the next-state bits so it moves on the same edge.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + (ADDR_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
      rs1_value_q  <= '0;
      rs2_value_q  <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[bus.rd] <= bus.rd_value;
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      rs1_value_q  <= rs1_value_d;
      rs2_value_q  <= rs2_value_d;
    end
  end

  assign bus.rs1_value  = rs1_value_q;
  assign bus.rs2_value  = rs2_value_q;
  // Pre-edge busy state: a same-cycle write does not hide the hazard.
  assign bus.rs1_busy   = busy_q[bus.rs1];
  assign bus.rs2_busy   = busy_q[bus.rs2];
  assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - self-checking bench for register_file_scoreboard

module tb_register_file_scoreboard;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  register_file_scoreboard_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  register_file_scoreboard #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_regs [DEPTH];
  logic [31:0] m_busy;
  logic [31:0] exp_rs1;
  logic [31:0] exp_rs2;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 32'h0;
    m_busy  = 32'h0;
    exp_rs1 = 32'h0;
    exp_rs2 = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write_enable && bus.rd == idx) return bus.rd_value;
`endif
    return m_regs[idx];
  endfunction

  task automatic idle();
    bus.read_enable  = 1'b0;
    bus.claim_enable = 1'b0;
    bus.write_enable = 1'b0;
  endtask

  // One clock edge: model consumes the inputs present at the edge, then sample #1 later.
  task automatic tick();
    logic [31:0] n1;
    logic [31:0] n2;
    n1 = exp_rs1;
    n2 = exp_rs2;
    if (bus.read_enable) begin
      n1 = model_read(bus.rs1);
      n2 = model_read(bus.rs2);
    end
    @(posedge clock);
    #1;
    exp_rs1 = n1;
    exp_rs2 = n2;
    if (bus.write_enable && bus.rd != 5'd0) m_regs[bus.rd] = bus.rd_value;
    if (bus.write_enable) m_busy[bus.rd] = 1'b0;
    if (bus.claim_enable) m_busy[bus.claim_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.rs1 = '0; bus.rs2 = '0; bus.claim_rd = '0; bus.rd = '0; bus.rd_value = '0;
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (bus.busy_count !== 6'd0) begin
      n_err++; $display("FAIL reset_busy_count_held: got %0d want 0", bus.busy_count);
    end
    @(negedge clock);
    reset = 1'b1;
    bus.read_enable = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd31;
    tick();
    idle();
    n_cmp++;
    if (bus.rs1_value !== 32'h0) begin
      n_err++; $display("FAIL reset_rs1_value: got %h want 0", bus.rs1_value);
    end
    n_cmp++;
    if (bus.rs2_value !== 32'h0) begin
      n_err++; $display("FAIL reset_rs2_value: got %h want 0", bus.rs2_value);
    end
    n_cmp++;
    if (bus.busy_count !== 6'd0) begin
      n_err++; $display("FAIL reset_busy_count: got %0d want 0", bus.busy_count);
    end
  endtask

  task automatic test_write_read();
    bus.write_enable = 1'b1; bus.rd = 5'd3; bus.rd_value = 32'hDEADBEEF;
    tick();
    idle();
    bus.read_enable = 1'b1; bus.rs1 = 5'd3;
    tick();
    idle();
    n_cmp++;
    if (bus.rs1_value !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_read_r3: got %h want deadbeef", bus.rs1_value);
    end
    bus.write_enable = 1'b1; bus.rd = 5'd0; bus.rd_value = 32'h1234;
    tick();
    idle();
    bus.read_enable = 1'b1; bus.rs2 = 5'd0;
    tick();
    idle();
    n_cmp++;
    if (bus.rs2_value !== 32'h0) begin
      n_err++; $display("FAIL zero_reg_read: got %h want 0", bus.rs2_value);
    end
    // Read enable low: outputs hold.
    bus.rs1 = 5'd7; bus.rs2 = 5'd3;
    tick();
    n_cmp++;
    if (bus.rs1_value !== 32'hDEADBEEF || bus.rs2_value !== 32'h0) begin
      n_err++; $display("FAIL read_hold: got %h/%h want deadbeef/0", bus.rs1_value, bus.rs2_value);
    end
  endtask

  task automatic test_collision();
    logic [31:0] want;
    bus.write_enable = 1'b1; bus.rd = 5'd7; bus.rd_value = 32'h11;
    tick();
    idle();
    bus.write_enable = 1'b1; bus.rd = 5'd7; bus.rd_value = 32'h22;
    bus.read_enable = 1'b1; bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    tick();
    idle();
`ifdef REGFILE_BYPASS_EN
    want = 32'h22;
`else
    want = 32'h11;
`endif
    n_cmp++;
    if (bus.rs1_value !== want || bus.rs2_value !== want) begin
      n_err++; $display("FAIL collision: got %h/%h want %h", bus.rs1_value, bus.rs2_value, want);
    end
    bus.read_enable = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (bus.rs1_value !== 32'h22) begin
      n_err++; $display("FAIL collision_followup: got %h want 22", bus.rs1_value);
    end
  endtask

  task automatic test_scoreboard();
    bus.claim_enable = 1'b1; bus.claim_rd = 5'd9;
    tick();
    idle();
    bus.rs1 = 5'd9;
    #1;
    n_cmp++;
    if (bus.rs1_busy !== 1'b1 || bus.busy_count !== 6'd1) begin
      n_err++; $display("FAIL claim_r9: got busy=%b cnt=%0d want 1/1", bus.rs1_busy, bus.busy_count);
    end
    bus.write_enable = 1'b1; bus.rd = 5'd9; bus.rd_value = 32'h99;
    #1;
    n_cmp++;
    if (bus.rs1_busy !== 1'b1) begin
      n_err++; $display("FAIL busy_pre_edge: got %b want 1", bus.rs1_busy);
    end
    tick();
    idle();
    n_cmp++;
    if (bus.rs1_busy !== 1'b0 || bus.busy_count !== 6'd0) begin
      n_err++; $display("FAIL write_clears_r9: got busy=%b cnt=%0d want 0/0", bus.rs1_busy, bus.busy_count);
    end
    bus.claim_enable = 1'b1; bus.claim_rd = 5'd4;
    tick();
    bus.write_enable = 1'b1; bus.rd = 5'd4; bus.rd_value = 32'h44;
    tick();
    idle();
    bus.rs2 = 5'd4;
    #1;
    n_cmp++;
    if (bus.rs2_busy !== 1'b1 || bus.busy_count !== 6'd1) begin
      n_err++; $display("FAIL claim_wins_r4: got busy=%b cnt=%0d want 1/1", bus.rs2_busy, bus.busy_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i < DEPTH; i++) begin
      bus.claim_enable = 1'b1; bus.claim_rd = 5'(i);
      tick();
    end
    idle();
    n_cmp++;
    if (bus.busy_count !== 6'd31) begin
      n_err++; $display("FAIL saturate_count: got %0d want 31", bus.busy_count);
    end
    bus.claim_enable = 1'b1; bus.claim_rd = 5'd0;
    tick();
    idle();
    bus.rs1 = 5'd0;
    #1;
    n_cmp++;
    if (bus.busy_count !== 6'd31 || bus.rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL claim_zero: got cnt=%0d busy=%b want 31/0", bus.busy_count, bus.rs1_busy);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      bus.read_enable  = 1'($urandom_range(0, 1));
      bus.claim_enable = 1'($urandom_range(0, 1));
      bus.write_enable = 1'($urandom_range(0, 1));
      bus.rs1      = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      bus.rs2      = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      bus.claim_rd = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      bus.rd       = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      bus.rd_value = $urandom;
      tick();
      n_cmp++;
      if (bus.rs1_value !== exp_rs1 || bus.rs2_value !== exp_rs2 ||
          bus.busy_count !== 6'($countones(m_busy)) ||
          bus.rs1_busy !== m_busy[bus.rs1] || bus.rs2_busy !== m_busy[bus.rs2]) begin
        n_err++;
        if (bad < 5)
          $display("FAIL random_cycle_%0d: got %h/%h cnt=%0d b=%b%b want %h/%h cnt=%0d b=%b%b",
                   c, bus.rs1_value, bus.rs2_value, bus.busy_count, bus.rs1_busy, bus.rs2_busy,
                   exp_rs1, exp_rs2, $countones(m_busy), m_busy[bus.rs1], m_busy[bus.rs2]);
        bad++;
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    time t0;
    #1 reset = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    idle();
    bus.write_enable = 1'b1; bus.rd = 5'd1; bus.rd_value = 32'hABCD;
    tick();
    idle();
    bus.read_enable = 1'b1; bus.rs1 = 5'd1;
    for (int i = 2; i <= 6; i++) begin
      bus.claim_enable = 1'b1; bus.claim_rd = 5'(i);
      tick();
      bus.read_enable = 1'b0;
    end
    idle();
    bus.rs1 = 5'd2;
    #1;
    n_cmp++;
    if (bus.busy_count !== 6'd5 || bus.rs1_value !== 32'hABCD) begin
      n_err++; $display("FAIL async_setup: got cnt=%0d v=%h want 5/abcd", bus.busy_count, bus.rs1_value);
    end
    t0 = $time;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.busy_count !== 6'd0 || bus.rs1_value !== 32'h0 || bus.rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got cnt=%0d v=%h busy=%b want 0/0/0 at dt=%0t",
                        bus.busy_count, bus.rs1_value, bus.rs1_busy, $time - t0);
    end
    #2 reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_saturation();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Parametrised successor to the core's single-write, dual-read integer register file.
- Adds configurable data width and depth, a hard-wired zero register, and synchronous (registered) reads.
- Adds a per-register busy scoreboard so the issue stage can detect RAW hazards against in-flight writes.
- Sits between decode/issue (reads, claims) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy; when 0 register 0 is ordinary.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- read_enable  input  1  capture rs1/rs2 read data this cycle.
- rs1  input  ADDR_W  read port 1 index.
- rs2  input  ADDR_W  read port 2 index.
- rs1_value  output  XLEN  registered read data, port 1.
- rs2_value  output  XLEN  registered read data, port 2.
- rs1_busy  output  1  combinational: register rs1 has a pending write.
- rs2_busy  output  1  combinational: register rs2 has a pending write.
- claim_enable  input  1  mark claim_rd busy (instruction issued with destination).
- claim_rd  input  ADDR_W  destination being claimed.
- write_enable  input  1  writeback strobe.
- rd  input  ADDR_W  writeback destination.
- rd_value  input  XLEN  writeback data.
- busy_count  output  ADDR_W+1  number of busy registers.

Behaviour:
- Reset (reset=0, async): all registers cleared to 0, all busy bits cleared, rs1_value/rs2_value = 0, busy_count = 0. Reset mid-operation discards pending claims and writes immediately.
- Write: on a rising edge with write_enable=1, registers[rd] <= rd_value. The write is ignored when ZERO_REG=1 and rd=0.
- Read latency is 1 cycle:
  - On a rising edge with read_enable=1, rs1_value/rs2_value load registers[rs1]/registers[rs2].
  - With read_enable=0 the outputs hold their previous values.
  - When ZERO_REG=1, index 0 always loads 0.
  - rs1 = rs2 is legal; both ports return the same value.
- Read/write collision (same edge, read index = rd, write_enable=1, rd not the zero register): the result is set by REGFILE_BYPASS_EN (below).
- Scoreboard:
  - claim_enable=1 sets busy[claim_rd].
  - write_enable=1 clears busy[rd].
  - Same edge, claim_rd = rd: the bit ends set, because the claim is a newer producer.
  - Claim of an already-busy register: the bit stays set, with no error.
  - Write to a non-busy register: legal, the data is written and the busy bit stays clear.
  - When ZERO_REG=1, claims of and writes to register 0 never set its bit.
- rs1_busy/rs2_busy reflect busy bits as registered (pre-edge state); they are not combinationally cleared by a same-cycle write.
- busy_count: registered population count of busy bits. It is updated in the same edge as the bits, ranges 0..2**ADDR_W (or 2**ADDR_W-1 when ZERO_REG=1), and never wraps.
- No X propagation: unwritten registers read 0 after reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-first. On a collision the read port loads rd_value, giving a new-value read in the same edge.
- Undefined: read-first. On a collision the read port loads the old register contents; the new value is visible on a read issued one cycle later.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- Reset: hold reset=0, then release; read_enable with rs1=5, rs2=31 -> next cycle rs1_value=0, rs2_value=0, busy_count=0.
- Write/read: write rd=3 value 0xDEADBEEF; next cycle read rs1=3 -> following cycle rs1_value=0xDEADBEEF. Write rd=0 value 0x1234 (ZERO_REG=1), read rs2=0 -> rs2_value=0.
- Collision: register 7 holds 0x11; same edge write rd=7 value 0x22 and read rs1=7 -> rs1_value=0x22 with REGFILE_BYPASS_EN, 0x11 without.
- Scoreboard: claim rd=9 -> rs1_busy=1 for rs1=9, busy_count=1. Write rd=9 -> busy clears, busy_count=0. Same-edge claim rd=4 and write rd=4 with busy[4] already set -> busy[4] stays 1.
- Saturation: claim all 31 non-zero registers on consecutive cycles -> busy_count=31. Claim register 0 -> busy_count unchanged, rs1_busy=0 for rs1=0.
- Async reset mid-operation: with busy_count=5 and rs1_value=0xABCD, drop reset between clock edges -> outputs go to 0 immediately, without waiting for a clock edge.
